addr4u_err_monitor: RTL and testbench

ADDR4U_ERR_MONITOR -- requirements
Module: addr4u_err_monitor

---
 rtl/addr4u_err_monitor.sv | 183 ++++++++++++++++++
 tb/tb_addr4u_err_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr4u_err_monitor.sv
// Checker stage for a 4-bit unsigned adder. Compares the adder result with the
// exact sum and reports error count, worst error and error sum per window.
module addr4u_err_monitor #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         a,
    input  logic [3:0]         b,
    input  logic [4:0]         sum,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [CNT_W-1:0]   rpt_err_cnt,
    output logic [4:0]         rpt_max_err,
    output logic [CNT_W+4:0]   rpt_err_sum
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    // Absolute distance between the exact 5-bit sum and the observed result.
    function automatic logic [4:0] abs_err(input logic [3:0] op_a,
                                           input logic [3:0] op_b,
                                           input logic [4:0] res);
        logic [4:0] exact;
        exact = {1'b0, op_a} + {1'b0, op_b};
        if (exact >= res) begin
            abs_err = exact - res;
        end else begin
            abs_err = res - exact;
        end
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               in_ready_r;
    logic               rpt_valid_r;
    logic               accept_s;
    logic               rpt_done_s;
    logic [CNT_W-1:0]   smp_cnt_r;

    logic               s1_valid_r;
    logic [3:0]         s1_a_r;
    logic [3:0]         s1_b_r;
    logic [4:0]         s1_sum_r;
    logic               s2_valid_r;
    logic [4:0]         s2_err_r;
    logic               s2_mis_r;

    logic [CNT_W-1:0]   err_cnt_r;
    logic [4:0]         max_err_r;
    logic [CNT_W+4:0]   err_sum_r;

    assign accept_s   = in_valid & in_ready_r;
    assign rpt_done_s = rpt_valid_r & rpt_ready;

    // Next-state logic; a started window always runs to its report.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && (smp_cnt_r == WIN_LAST)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (!s1_valid_r && !s2_valid_r) begin
                    state_s = REPORT;
                end else begin
                    state_s = DRAIN;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    state_s = en ? RUN : IDLE;
                end else begin
                    state_s = REPORT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with handshake flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            rpt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == RUN);
            rpt_valid_r <= (state_s == REPORT);
        end
    end

    // Accepted-sample counter for the current window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_cnt_r <= {CNT_W{1'b0}};
        end else if (rpt_done_s) begin
            smp_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            smp_cnt_r <= smp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            smp_cnt_r <= smp_cnt_r;
        end
    end

    // Two pipeline stages: capture the sample, then compute its error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= 4'd0;
            s1_b_r     <= 4'd0;
            s1_sum_r   <= 5'd0;
            s2_valid_r <= 1'b0;
            s2_err_r   <= 5'd0;
            s2_mis_r   <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_a_r   <= a;
                s1_b_r   <= b;
                s1_sum_r <= sum;
            end else begin
                s1_a_r   <= s1_a_r;
                s1_b_r   <= s1_b_r;
                s1_sum_r <= s1_sum_r;
            end
            s2_valid_r <= s1_valid_r;
            s2_err_r   <= abs_err(s1_a_r, s1_b_r, s1_sum_r);
            s2_mis_r   <= (abs_err(s1_a_r, s1_b_r, s1_sum_r) != 5'd0);
        end
    end

    // Window statistics; the report handshake starts a fresh window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
            max_err_r <= 5'd0;
            err_sum_r <= {(CNT_W+5){1'b0}};
        end else if (rpt_done_s) begin
            err_cnt_r <= {CNT_W{1'b0}};
            max_err_r <= 5'd0;
            err_sum_r <= {(CNT_W+5){1'b0}};
        end else if (s2_valid_r) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, s2_mis_r};
            max_err_r <= (s2_err_r > max_err_r) ? s2_err_r : max_err_r;
            err_sum_r <= err_sum_r + {{CNT_W{1'b0}}, s2_err_r};
        end else begin
            err_cnt_r <= err_cnt_r;
            max_err_r <= max_err_r;
            err_sum_r <= err_sum_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign rpt_valid   = rpt_valid_r;
    assign rpt_err_cnt = err_cnt_r;
    assign rpt_max_err = max_err_r;
    assign rpt_err_sum = err_sum_r;

endmodule

// File: tb/tb_addr4u_err_monitor.sv
// Self-checking bench for addr4u_err_monitor with WINDOW=4: table of windows
// with expected reports, a report scoreboard, and hand-written corner sequences.
module tb_addr4u_err_monitor;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
    } samp_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic [4:0]  mx;
        logic [20:0] sm;
    } rpt_t;

    typedef struct {
        samp_t [3:0] s;
        rpt_t        exp;
        bit          gap;
        bit          bp;
        bit          drop_en;
        bit          en_hs;
    } win_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [4:0]  sum;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [15:0] rpt_err_cnt;
    logic [4:0]  rpt_max_err;
    logic [20:0] rpt_err_sum;

    int   total = 0;
    int   bad   = 0;
    win_t tbl [4];
    rpt_t exp_q [$];

    addr4u_err_monitor #(.WINDOW(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sum(sum),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_err_cnt(rpt_err_cnt), .rpt_max_err(rpt_max_err), .rpt_err_sum(rpt_err_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic samp_t mk(input int x, input int y, input int s);
        samp_t r;
        r.a   = 4'(x);
        r.b   = 4'(y);
        r.sum = 5'(s);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        a   = 4'd15;
        b   = 4'd15;
        sum = 5'd0;
    endtask

    task automatic send(input samp_t sm);
        int g = 0;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        chk("ready_wait", in_ready, 1);
        a        = sm.a;
        b        = sm.b;
        sum      = sm.sum;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_errcnt"}, rpt_err_cnt, 0);
        chk({tag, "_maxerr"}, rpt_max_err, 0);
        chk({tag, "_errsum"}, rpt_err_sum, 0);
    endtask

    task automatic handshake(input bit en_val);
        en        = en_val;
        in_valid  = 1'b0;
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        chk("hs_rpt_valid", rpt_valid, 0);
        chk("hs_in_ready", in_ready, en_val);
        chk_zero("hs");
        if (!en_val) begin
            repeat (2) begin
                tick();
                chk("idle_in_ready", in_ready, 0);
            end
            en = 1'b1;
            tick();
            chk("reenable_in_ready", in_ready, 1);
        end
    endtask

    task automatic run_window(input win_t w);
        rpt_t e;
        int   lat = 0;
        exp_q.push_back(w.exp);
        for (int i = 0; i < 4; i++) begin
            send(w.s[i]);
            if (w.drop_en && i == 0) en = 1'b0;
            if (w.gap && i < 3) begin
                drive_junk();
                tick();
            end
        end
        // Offer junk while the monitor is not ready; it must be ignored.
        drive_junk();
        in_valid = 1'b1;
        while (!rpt_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("report_latency", lat, 3);
        chk("report_in_ready", in_ready, 0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("err_cnt", rpt_err_cnt, {16'd0, e.cnt});
            chk("max_err", rpt_max_err, {27'd0, e.mx});
            chk("err_sum", rpt_err_sum, {11'd0, e.sm});
            if (w.bp) begin
                for (int c = 0; c < 10; c++) begin
                    tick();
                    chk("bp_rpt_valid", rpt_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_err_sum", rpt_err_sum, {11'd0, e.sm});
                    chk("bp_max_err", rpt_max_err, {27'd0, e.mx});
                end
            end
        end
        handshake(w.en_hs);
    endtask

    initial begin
        tbl[0].s[0] = mk(3, 5, 8);   tbl[0].s[1] = mk(3, 5, 8);
        tbl[0].s[2] = mk(3, 5, 8);   tbl[0].s[3] = mk(3, 5, 8);
        tbl[0].exp  = '{16'd0, 5'd0, 21'd0};
        tbl[0].gap = 1'b0; tbl[0].bp = 1'b0; tbl[0].drop_en = 1'b0; tbl[0].en_hs = 1'b1;

        tbl[1].s[0] = mk(15, 15, 30); tbl[1].s[1] = mk(1, 2, 0);
        tbl[1].s[2] = mk(8, 8, 31);   tbl[1].s[3] = mk(0, 0, 1);
        tbl[1].exp  = '{16'd3, 5'd15, 21'd19};
        tbl[1].gap = 1'b0; tbl[1].bp = 1'b1; tbl[1].drop_en = 1'b0; tbl[1].en_hs = 1'b1;

        tbl[2].s[0] = mk(15, 15, 0);  tbl[2].s[1] = mk(0, 0, 31);
        tbl[2].s[2] = mk(7, 9, 16);   tbl[2].s[3] = mk(4, 4, 0);
        tbl[2].exp  = '{16'd3, 5'd31, 21'd69};
        tbl[2].gap = 1'b1; tbl[2].bp = 1'b0; tbl[2].drop_en = 1'b1; tbl[2].en_hs = 1'b0;

        tbl[3].s[0] = mk(1, 1, 3);    tbl[3].s[1] = mk(2, 2, 3);
        tbl[3].s[2] = mk(5, 5, 9);    tbl[3].s[3] = mk(0, 1, 0);
        tbl[3].exp  = '{16'd4, 5'd1, 21'd4};
        tbl[3].gap = 1'b1; tbl[3].bp = 1'b0; tbl[3].drop_en = 1'b0; tbl[3].en_hs = 1'b1;

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; rpt_ready = 1'b0;
        a = 4'd0; b = 4'd0; sum = 5'd0;
        repeat (3) tick();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_rpt_valid", rpt_valid, 0);
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("run_after_reset", in_ready, 1);

        for (int w = 0; w < 4; w++) begin
            run_window(tbl[w]);
        end

        // Reset one cycle after the last accept: window discarded, no report.
        for (int i = 0; i < 4; i++) send(tbl[1].s[i]);
        tick();
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        chk("drain_rst_in_ready", in_ready, 0);
        chk("drain_rst_rpt_valid", rpt_valid, 0);
        chk_zero("drain_rst");
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_rpt_valid", rpt_valid, 0);
            chk("post_rst_in_ready", in_ready, 0);
        end
        en = 1'b1;
        tick();
        chk("post_rst_run", in_ready, 1);
        run_window(tbl[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
